// File: rtl/dma_ctrl.sv
// dma_ctrl: single-channel block-copy DMA over a single-ported word memory.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        begin a copy (sampled in IDLE) / terminate an active copy
//   src_addr, dst_addr  first source/destination word address, latched at start
//   len                 word count, latched at start (0 gives an immediate done)
//   busy, done          copy in progress / one-cycle completion pulse
//   mem_addr, mem_re, mem_we, mem_wrt_data, mem_rd_data  memory port
module dma_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [15:0]       len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wrt_data,
    input  logic [DATA_W-1:0] mem_rd_data
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] src_q, dst_q, addr_n;
    logic [15:0] len_q, i, i_n;
    logic re_n, we_n, done_n;
    logic launch;
    assign busy = state != IDLE;
    assign launch = state == IDLE && start && len != 16'd0;
    // Memory-side outputs are computed for the coming cycle and registered,
    // so they are stable when the memory samples them on the negedge.
    always_comb begin
        state_n = state;
        i_n     = i;
        addr_n  = mem_addr;
        re_n    = 1'b0;
        we_n    = 1'b0;
        done_n  = 1'b0;
        if (abort && state != IDLE) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        state_n = READ;
                        i_n     = 16'd0;
                        re_n    = 1'b1;
                        addr_n  = src_addr;
                    end else begin
                        done_n = start;
                    end
                end
                READ: begin
                    state_n = WRITE;
                    we_n    = 1'b1;
                    addr_n  = dst_q + ADDR_W'(i);
                end
                WRITE: begin
                    i_n = i + 16'd1;
                    if (i_n == len_q) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = READ;
                        re_n    = 1'b1;
                        addr_n  = src_q + ADDR_W'(i_n);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            i            <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            mem_addr     <= '0;
            mem_re       <= 1'b0;
            mem_we       <= 1'b0;
            done         <= 1'b0;
            mem_wrt_data <= '0;
        end else begin
            state    <= state_n;
            i        <= i_n;
            mem_addr <= addr_n;
            mem_re   <= re_n;
            mem_we   <= we_n;
            done     <= done_n;
            if (launch) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                len_q <= len;
            end
            // The holding register doubles as the write-data output.
            if (state == READ)
                mem_wrt_data <= mem_rd_data;
        end
    end
endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl: directed self-checking bench for dma_ctrl with a behavioural memory.
module tb_dma_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, mem_re, mem_we;
    logic [15:0] mem_addr, mem_wrt_data;
    logic [15:0] mem_rd_data = '0;
    logic [15:0] mem [0:65535];
    logic [15:0] rd_log[$];
    logic [15:0] wr_log[$];
    int errs = 0;
    int checks = 0;
    int bcnt, dcyc, dcnt;

    dma_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_we(mem_we),
        .mem_wrt_data(mem_wrt_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory samples on the negedge; read data is ready by the next posedge.
    always @(negedge clk) begin
        chk("re_we_exclusive", {31'd0, mem_re && mem_we}, 32'd0);
        if (mem_we) begin
            mem[mem_addr] <= mem_wrt_data;
            wr_log.push_back(mem_addr);
        end
        if (mem_re) begin
            mem_rd_data <= mem[mem_addr];
            rd_log.push_back(mem_addr);
        end
    end

    // Cycle c is observed 1 time unit after posedge P(c-1); start is sampled at P0.
    // ab: cycle in which abort is held high; sb: cycle in which a stray start is pulsed.
    task automatic run(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                       input int ab, input int sb, output int bc, output int dc, output int dn);
        rd_log.delete();
        wr_log.delete();
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bc = 0; dn = 0; dc = -1;
        for (int c = 1; c <= 40; c++) begin
            if (busy) bc++;
            if (done) begin dn++; dc = c; end
            abort = (c == ab);
            start = (c == sb);
            if (c == sb) begin
                src_addr = 16'h5555; dst_addr = 16'h6666; len = 16'd3;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        mem[16'h0010] = 16'h00A1; mem[16'h0011] = 16'h00B2;
        mem[16'h0012] = 16'h00C3; mem[16'h0013] = 16'h00D4;
        mem[16'hFFFF] = 16'h1234; mem[16'h0000] = 16'h5678;
        for (int k = 0; k < 8; k++) mem[16'h0300 + 16'(k)] = 16'hA000 + 16'(k);
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_re", {31'd0, mem_re}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, mem_wrt_data}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Basic copy with a stray start in cycle 3.
        run(16'h0010, 16'h0100, 16'd4, 0, 3, bcnt, dcyc, dcnt);
        chk("basic_busy_cycles", bcnt, 8);
        chk("basic_done_count", dcnt, 1);
        chk("basic_done_cycle", dcyc, 9);
        chk("basic_m0", {16'd0, mem[16'h0100]}, 32'h00A1);
        chk("basic_m1", {16'd0, mem[16'h0101]}, 32'h00B2);
        chk("basic_m2", {16'd0, mem[16'h0102]}, 32'h00C3);
        chk("basic_m3", {16'd0, mem[16'h0103]}, 32'h00D4);
        chk("basic_writes", wr_log.size(), 4);
        chk("basic_reads", rd_log.size(), 4);
        if (rd_log.size() == 4) chk("basic_rd3", {16'd0, rd_log[3]}, 32'h0013);
        if (wr_log.size() == 4) chk("basic_wr3", {16'd0, wr_log[3]}, 32'h0103);

        // Zero-length request.
        run(16'h0020, 16'h0040, 16'd0, 0, 0, bcnt, dcyc, dcnt);
        chk("zero_done_cycle", dcyc, 1);
        chk("zero_done_count", dcnt, 1);
        chk("zero_busy", bcnt, 0);
        chk("zero_reads", rd_log.size(), 0);
        chk("zero_writes", wr_log.size(), 0);

        // Address wrap.
        run(16'hFFFF, 16'h1FFF, 16'd2, 0, 0, bcnt, dcyc, dcnt);
        chk("wrap_done_cycle", dcyc, 5);
        chk("wrap_busy", bcnt, 4);
        if (rd_log.size() == 2) begin
            chk("wrap_rd0", {16'd0, rd_log[0]}, 32'hFFFF);
            chk("wrap_rd1", {16'd0, rd_log[1]}, 32'h0000);
        end else chk("wrap_reads", rd_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("wrap_wr0", {16'd0, wr_log[0]}, 32'h1FFF);
            chk("wrap_wr1", {16'd0, wr_log[1]}, 32'h2000);
        end else chk("wrap_writes", wr_log.size(), 2);
        chk("wrap_m0", {16'd0, mem[16'h1FFF]}, 32'h1234);
        chk("wrap_m1", {16'd0, mem[16'h2000]}, 32'h5678);

        // Abort during the READ of word 2.
        run(16'h0300, 16'h0400, 16'd8, 5, 0, bcnt, dcyc, dcnt);
        chk("abort_busy", bcnt, 5);
        chk("abort_done_count", dcnt, 0);
        chk("abort_writes", wr_log.size(), 2);
        chk("abort_reads", rd_log.size(), 3);
        chk("abort_m0", {16'd0, mem[16'h0400]}, 32'hA000);
        chk("abort_m1", {16'd0, mem[16'h0401]}, 32'hA001);

        // Asynchronous reset in the middle of the first WRITE cycle.
        @(negedge clk);
        src_addr = 16'h0010; dst_addr = 16'h0500; len = 16'd4; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_we", {31'd0, mem_we}, 32'd1);
        #2; rst = 1'b1; #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_we", {31'd0, mem_we}, 32'd0);
        chk("arst_re", {31'd0, mem_re}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_done", {31'd0, done}, 32'd0);
        chk("post_rst_we", {31'd0, mem_we}, 32'd0);
        run(16'h0010, 16'h0500, 16'd4, 0, 0, bcnt, dcyc, dcnt);
        chk("fresh_done_cycle", dcyc, 9);
        chk("fresh_busy", bcnt, 8);
        chk("fresh_m0", {16'd0, mem[16'h0500]}, 32'h00A1);
        chk("fresh_m3", {16'd0, mem[16'h0503]}, 32'h00D4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
- REQ-001 Parameter ADDR_W, default 16, SHALL set the address width of src_addr, dst_addr and mem_addr.
- REQ-002 Parameter DATA_W, default 16, SHALL set the width of mem_wrt_data and mem_rd_data.
- REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on posedge clk.
- REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
- REQ-005 start  input  1  SHALL request a block copy; it is sampled only in IDLE.
- REQ-006 abort  input  1  SHALL terminate an active copy.
- REQ-007 src_addr  input  ADDR_W  SHALL give the first source word address; it is latched at start.
- REQ-008 dst_addr  input  ADDR_W  SHALL give the first destination word address; it is latched at start.
- REQ-009 len  input  16  SHALL give the word count; it is latched at start.
- REQ-010 busy  output  1  SHALL be high while a copy is in progress (READ or WRITE state).
- REQ-011 done  output  1  SHALL be a one-cycle completion pulse.
- REQ-012 mem_addr  output  ADDR_W  SHALL be the address presented to the single-ported data memory.
- REQ-013 mem_re  output  1  SHALL be the memory read enable.
- REQ-014 mem_we  output  1  SHALL be the memory write enable.
- REQ-015 mem_wrt_data  output  DATA_W  SHALL be the memory write data.
- REQ-016 mem_rd_data  input  DATA_W  SHALL be the memory read data.
  - The memory samples address and enables on negedge clk.
  - Read data is valid by the following posedge.

Function
- REQ-017 Every memory-side output SHALL be driven from a register clocked on posedge clk, so it is stable at the memory's negedge sample point.
- REQ-018 The FSM SHALL have exactly three states: IDLE, READ and WRITE.
  - busy = (state != IDLE).
- REQ-019 In IDLE, start=1 with len!=0 SHALL:
  - latch src_addr, dst_addr and len;
  - clear the word index i to 0;
  - enter READ.
- REQ-020 In IDLE, start=1 with len==0 SHALL pulse done in the next cycle, SHALL stay in IDLE and SHALL issue no memory access.
- REQ-021 In READ, the block SHALL drive mem_re=1, mem_we=0 and mem_addr=src+i.
  - At the closing posedge it SHALL capture mem_rd_data into a holding register and enter WRITE.
- REQ-022 In WRITE, the block SHALL drive mem_we=1, mem_re=0, mem_addr=dst+i and mem_wrt_data=holding register.
  - At the closing posedge, i SHALL increment.
  - If the new i equals len, the block SHALL return to IDLE with done=1 for exactly one cycle.
  - Otherwise it SHALL return to READ.
- REQ-023 Timing: start sampled at posedge P0 SHALL give:
  - word k read in cycle 2k+1;
  - word k written in cycle 2k+2;
  - done high in cycle 2·len+1;
  - busy high for exactly 2·len cycles.
- REQ-024 mem_re and mem_we SHALL never both be 1 in the same cycle.
  - Both SHALL be 0 in IDLE.
- REQ-025 Address arithmetic SHALL be modulo 2^ADDR_W; src+i and dst+i wrap from all-ones to 0 without error.
- REQ-026 start asserted while busy SHALL be ignored and SHALL NOT change the latched parameters.
- REQ-027 abort=1 sampled in READ or WRITE SHALL:
  - force IDLE at that posedge;
  - deassert mem_re and mem_we from the next cycle;
  - not pulse done.
  - A WRITE cycle in progress at that posedge still completes at its negedge.
- REQ-028 abort takes priority over every other transition; abort in IDLE SHALL have no effect.
- REQ-029 Overlapping src/dst ranges SHALL be copied in ascending address order with no hazard protection.

Reset
- REQ-030 While rst=1, asynchronously and independent of clk, the block SHALL force:
  - state=IDLE;
  - busy=0, done=0, mem_re=0, mem_we=0;
  - mem_addr=0, mem_wrt_data=0;
  - i=0 and holding register=0.
- REQ-031 Reset asserted mid-copy SHALL abandon the copy with no done pulse.
  - The first cycle after rst deasserts SHALL be IDLE with all enables low.

Verification
- REQ-032 Basic copy: mem[0x0010..0x0013]={0xA1,0xB2,0xC3,0xD4}, start with src=0x0010, dst=0x0100, len=4.
  - mem[0x0100..0x0103] SHALL match the source.
  - busy SHALL be high for 8 cycles.
  - done SHALL pulse once, in cycle 9.
- REQ-033 len=0: start with src=0x0020, dst=0x0040.
  - done SHALL pulse in cycle 1.
  - busy, mem_re and mem_we SHALL stay 0.
- REQ-034 Wrap: src=0xFFFF, dst=0x1FFF, len=2.
  - Reads SHALL go to 0xFFFF then 0x0000.
  - Writes SHALL go to 0x1FFF then 0x2000.
- REQ-035 Abort: len=8, abort pulsed in cycle 5 (READ of word 2).
  - Only dst+0 and dst+1 SHALL be written.
  - No done pulse; busy=0 from cycle 6.
- REQ-036 Async reset: rst asserted between clock edges mid-WRITE.
  - busy, mem_we and mem_re SHALL drop to 0 immediately.
  - A start after release SHALL perform a full fresh copy.
- REQ-037 Every test: an assertion SHALL check that (mem_re && mem_we) never occurs, and that start pulsed while busy leaves the transfer unchanged.
